// File: rtl/lzc_norm_pipe.sv
// Two-stage leading-zero/one counter and normalizer with valid/ready flow control.
// Stage 1 registers count, all-flag, mode and operand; stage 2 registers the shifted result.
module lzc_norm_pipe #(
    parameter int N = 16,
    localparam int C = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic         in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [C-1:0] out_count,
    output logic [N-1:0] out_norm,
    output logic         out_all,
    output logic         out_mode
);

    logic         s1_v_q,     s1_v_d;
    logic [C-1:0] s1_count_q, s1_count_d;
    logic         s1_all_q,   s1_all_d;
    logic         s1_mode_q,  s1_mode_d;
    logic [N-1:0] s1_data_q,  s1_data_d;

    logic         s2_v_q,     s2_v_d;
    logic [C-1:0] s2_count_q, s2_count_d;
    logic [N-1:0] s2_norm_q,  s2_norm_d;
    logic         s2_all_q,   s2_all_d;
    logic         s2_mode_q,  s2_mode_d;

    logic         s1_adv;
    logic         s2_adv;
    logic [N-1:0] scan;
    logic [C-1:0] lz_count;
    logic         lz_all;

    // A stage may load when it is empty or its occupant leaves this cycle.
    assign s2_adv   = !s2_v_q || out_ready;
    assign s1_adv   = !s1_v_q || s2_adv;
    assign in_ready = s1_adv;

    // Counting leading ones is counting leading zeros of the inverted operand.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        scan     = in_mode ? ~in_data : in_data;
        lz_count = C'(N);
        for (int i = 0; i < N; i++) begin
            if (scan[i]) lz_count = C'(N - 1 - i);
        end
        lz_all   = (scan == '0);
    end

    always_comb begin
        s1_v_d     = s1_v_q;
        s1_count_d = s1_count_q;
        s1_all_d   = s1_all_q;
        s1_mode_d  = s1_mode_q;
        s1_data_d  = s1_data_q;
        s2_v_d     = s2_v_q;
        s2_count_d = s2_count_q;
        s2_norm_d  = s2_norm_q;
        s2_all_d   = s2_all_q;
        s2_mode_d  = s2_mode_q;

        if (s1_adv) begin
            s1_v_d = in_valid;
            // Payload only loads on a real beat, so idle-cycle data never reaches the output.
            if (in_valid) begin
                s1_count_d = lz_count;
                s1_all_d   = lz_all;
                s1_mode_d  = in_mode;
                s1_data_d  = in_data;
            end
        end

        if (s2_adv) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_count_d = s1_count_q;
                s2_norm_d  = s1_data_q << s1_count_q;
                s2_all_d   = s1_all_q;
                s2_mode_d  = s1_mode_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            s1_v_q     <= 1'b0;
            s1_count_q <= '0;
            s1_all_q   <= 1'b0;
            s1_mode_q  <= 1'b0;
            s1_data_q  <= '0;
            s2_v_q     <= 1'b0;
            s2_count_q <= '0;
            s2_norm_q  <= '0;
            s2_all_q   <= 1'b0;
            s2_mode_q  <= 1'b0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_count_q <= s1_count_d;
            s1_all_q   <= s1_all_d;
            s1_mode_q  <= s1_mode_d;
            s1_data_q  <= s1_data_d;
            s2_v_q     <= s2_v_d;
            s2_count_q <= s2_count_d;
            s2_norm_q  <= s2_norm_d;
            s2_all_q   <= s2_all_d;
            s2_mode_q  <= s2_mode_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_count = s2_count_q;
    assign out_norm  = s2_norm_q;
    assign out_all   = s2_all_q;
    assign out_mode  = s2_mode_q;

endmodule

// File: tb/tb_lzc_norm_pipe.sv
// Scoreboard bench for lzc_norm_pipe: N=16 instance under random flow control plus an N=12 instance.
module tb_lzc_norm_pipe;

    typedef struct {
        logic [4:0]  count;
        logic [15:0] norm;
        logic        all;
        logic        mode;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_count;
    logic [15:0] out_norm;
    logic        out_all;
    logic        out_mode;

    logic        v12 = 1'b0;
    logic        rdy12;
    logic [11:0] d12 = '0;
    logic        m12 = 1'b0;
    logic        ov12;
    logic [3:0]  oc12;
    logic [11:0] on12;
    logic        oa12;
    logic        om12;

    int   n_total = 0;
    int   n_pass  = 0;
    bit   rand_ready = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    lzc_norm_pipe #(.N(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_norm(out_norm), .out_all(out_all), .out_mode(out_mode)
    );

    lzc_norm_pipe #(.N(12)) dut12 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v12), .in_ready(rdy12), .in_data(d12), .in_mode(m12),
        .out_valid(ov12), .out_ready(1'b1), .out_count(oc12),
        .out_norm(on12), .out_all(oa12), .out_mode(om12)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: walk from the MSB while bits equal the mode, then shift and mask to n bits.
    function automatic void model(input logic [63:0] d, input logic m, input int n,
                                  output int cnt, output logic [63:0] norm);
        cnt = 0;
        while (cnt < n && d[n-1-cnt] == m) cnt++;
        norm = (d << cnt) & ((64'd1 << n) - 64'd1);
    endfunction

    function automatic exp_t model16(input logic [15:0] d, input logic m);
        int          c;
        logic [63:0] nrm;
        exp_t        e;
        model({48'd0, d}, m, 16, c, nrm);
        e.count = 5'(c);
        e.norm  = nrm[15:0];
        e.all   = (c == 16);
        e.mode  = m;
        return e;
    endfunction

    task automatic send(input logic [15:0] d, input logic m, input exp_t e);
        int w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        #1;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!in_ready) begin
            check("send_timeout", 64'd1, 64'd0);
            in_valid = 1'b0;
        end else begin
            sb.push_back(e);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_data  = 16'($urandom);
            in_mode  = 1'($urandom);
        end
    endtask

    task automatic send_exp(input logic [15:0] d, input logic m,
                            input logic [4:0] c, input logic [15:0] nrm, input logic a);
        exp_t e;
        e.count = c;
        e.norm  = nrm;
        e.all   = a;
        e.mode  = m;
        send(d, m, e);
    endtask

    task automatic drain();
        int w = 0;
        while (sb.size() != 0 && w < 1000) begin
            @(negedge clk);
            w++;
        end
        check("drain_empty", 64'(sb.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic t12(input logic [11:0] d, input logic m, input string name);
        int          c;
        logic [63:0] nrm;
        model({52'd0, d}, m, 12, c, nrm);
        @(negedge clk);
        v12 = 1'b1;
        d12 = d;
        m12 = m;
        @(posedge clk);
        #1;
        v12 = 1'b0;
        d12 = 12'($urandom);
        check({name, "_lat1"}, 64'(ov12), 64'd0);
        @(posedge clk);
        #1;
        check({name, "_valid"}, 64'(ov12), 64'd1);
        check({name, "_count"}, 64'(oc12), 64'(c));
        check({name, "_norm"},  64'(on12), nrm);
        check({name, "_all"},   64'(oa12), 64'(c == 12));
    endtask

    // Monitor: pops on every output transfer and checks stability while stalled.
    initial begin
        bit          hold = 1'b0;
        logic [4:0]  p_count;
        logic [15:0] p_norm;
        logic        p_all, p_mode;
        exp_t        e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_count", 64'(out_count), 64'(p_count));
                    check("stall_norm",  64'(out_norm),  64'(p_norm));
                    check("stall_flags", 64'({out_all, out_mode}), 64'({p_all, p_mode}));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_output", 64'd1, 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("count", 64'(out_count), 64'(e.count));
                        check("norm",  64'(out_norm),  64'(e.norm));
                        check("all",   64'(out_all),   64'(e.all));
                        check("mode",  64'(out_mode),  64'(e.mode));
                    end
                end
                hold    = out_valid && !out_ready;
                p_count = out_count;
                p_norm  = out_norm;
                p_all   = out_all;
                p_mode  = out_mode;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          seen;
        logic [15:0] x;
        logic        m;
        int          k;

        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_norm",  64'(out_norm),  64'd0);
        check("rst_flags",     64'({out_all, out_mode}), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Latency with an empty pipe and out_ready high.
        out_ready = 1'b1;
        send_exp(16'h0100, 1'b0, 5'd7, 16'h8000, 1'b0);
        check("lat_s1", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("lat_s2", 64'(out_valid), 64'd1);
        drain();

        send_exp(16'h0000, 1'b0, 5'd16, 16'h0000, 1'b1);
        send_exp(16'h8000, 1'b0, 5'd0,  16'h8000, 1'b0);
        send_exp(16'hF0FF, 1'b1, 5'd4,  16'h0FF0, 1'b0);
        send_exp(16'hFFFF, 1'b1, 5'd16, 16'h0000, 1'b1);
        send_exp(16'h0001, 1'b0, 5'd15, 16'h8000, 1'b0);
        send_exp(16'h7FFF, 1'b1, 5'd0,  16'h7FFF, 1'b0);
        drain();

        // Backpressure: two beats fill the pipe, then in_ready must drop.
        @(negedge clk);
        out_ready = 1'b0;
        send_exp(16'h0100, 1'b0, 5'd7, 16'h8000, 1'b0);
        send_exp(16'h00F0, 1'b0, 5'd8, 16'hF000, 1'b0);
        @(negedge clk);
        #1;
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid",    64'(out_valid), 64'd1);
        fork
            begin
                send_exp(16'hE000, 1'b1, 5'd3, 16'h0000, 1'b0);
                send_exp(16'h0003, 1'b0, 5'd14, 16'hC000, 1'b0);
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two beats in flight: outputs clear at once, nothing stale after release.
        @(negedge clk);
        out_ready = 1'b0;
        send_exp(16'h0010, 1'b0, 5'd11, 16'h8000, 1'b0);
        send_exp(16'hFF00, 1'b1, 5'd8,  16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_count", 64'(out_count), 64'd0);
        check("mid_rst_out_norm",  64'(out_norm),  64'd0);
        check("mid_rst_in_ready",  64'(in_ready),  64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("no_stale_output", 64'(seen), 64'd0);

        // Random beats with random gaps and random downstream stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            k = $urandom_range(0, 16);
            x = 16'($urandom) >> k;
            m = 1'($urandom);
            if (m) x = ~x;
            send(x, m, model16(x, m));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        // Non-power-of-two width.
        t12(12'h001, 1'b0, "n12_001");
        t12(12'hFFE, 1'b1, "n12_ffe");
        t12(12'h000, 1'b0, "n12_zero");
        t12(12'hFFF, 1'b1, "n12_ones");
        t12(12'h800, 1'b0, "n12_msb");
        for (int i = 0; i < 8; i++) t12(12'($urandom) >> $urandom_range(0, 12), 1'($urandom), "n12_rand");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
